// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw pins, deframes
// 11-bit frames and folds E0/F0 prefixes into single make/break key events.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       keyboardCLK,
  input  logic       keyboardData,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_ONE = FW'(1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    dat_sync_reg;
  logic          filt_reg;
  logic          filt_d_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;
  logic          dat_bit;

  state_t        state_reg;
  state_t        state_next;
  logic [3:0]    bitcnt_reg;
  logic [10:1]   frame_reg;
  logic [TW-1:0] idle_cnt_reg;
  logic          ext_pend_reg;
  logic          brk_pend_reg;

  logic          timeout;
  logic          frame_ok;
  logic          emit;
  logic          err_next;
  logic          set_ext;
  logic          set_brk;
  logic          clr_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], keyboardCLK};
      dat_sync_reg <= {dat_sync_reg[0], keyboardData};
    end
  end

  // Filtered clock only follows the synchronised clock after FILTER_LEN
  // consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg     <= 1'b1;
      filt_d_reg   <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      filt_d_reg <= filt_reg;
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_MAX) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FILT_ONE;
      end
    end
  end

  assign fall    = filt_d_reg & ~filt_reg;
  assign dat_bit = dat_sync_reg[1];
  assign timeout = (state_reg == S_RECV) && !fall && (idle_cnt_reg == TO_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (fall && !dat_bit) state_next = S_RECV;
      S_RECV: begin
        if (fall && bitcnt_reg == 4'd10) state_next = S_CHECK;
        else if (timeout)                state_next = S_IDLE;
      end
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Frame shift-in and inter-edge watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_reg   <= 4'd0;
      frame_reg    <= '0;
      idle_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          idle_cnt_reg <= '0;
          if (fall && !dat_bit) bitcnt_reg <= 4'd1;
        end
        S_RECV: begin
          if (fall) begin
            frame_reg[bitcnt_reg] <= dat_bit;
            bitcnt_reg            <= bitcnt_reg + 4'd1;
            idle_cnt_reg          <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + TO_ONE;
          end
        end
        default: idle_cnt_reg <= '0;
      endcase
    end
  end

  always_comb begin
    busy     = (state_reg != S_IDLE);
    frame_ok = frame_reg[10] & (^frame_reg[9:1]);
    emit     = 1'b0;
    set_ext  = 1'b0;
    set_brk  = 1'b0;
    err_next = timeout;
    if (state_reg == S_CHECK) begin
      if (!frame_ok)                       err_next = 1'b1;
      else if (frame_reg[8:1] == 8'hE0)    set_ext  = 1'b1;
      else if (frame_reg[8:1] == 8'hF0)    set_brk  = 1'b1;
      else                                 emit     = 1'b1;
    end
    clr_pend = emit | err_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code         <= 8'h00;
      code_valid   <= 1'b0;
      is_break     <= 1'b0;
      is_extended  <= 1'b0;
      frame_err    <= 1'b0;
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
    end else begin
      code_valid <= emit;
      frame_err  <= err_next;
      if (emit) begin
        code        <= frame_reg[8:1];
        is_break    <= brk_pend_reg;
        is_extended <= ext_pend_reg;
      end
      if (clr_pend) begin
        ext_pend_reg <= 1'b0;
        brk_pend_reg <= 1'b0;
      end else begin
        if (set_ext) ext_pend_reg <= 1'b1;
        if (set_brk) brk_pend_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: table of single frames plus hand-written
// glitch, timeout and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

  localparam int FL = 4;
  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       keyboardCLK;
  logic       keyboardData;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .keyboardCLK(keyboardCLK), .keyboardData(keyboardData),
    .code(code), .code_valid(code_valid), .is_break(is_break), .is_extended(is_extended),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0;
  int n_err   = 0;
  int ev_cyc  = 0;
  int err_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (code_valid) begin n_valid++; ev_cyc = cyc; end
    if (frame_err)  begin n_err++;   err_cyc = cyc; end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    keyboardData = b;
    wait_cyc(20);
    keyboardCLK   = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(40);
    keyboardCLK = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = d;
    bits[9]    = ~(^d) ^ bad_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    keyboardData = 1'b1;
  endtask

  // kind: 0 = no pulse, 1 = code_valid, 2 = frame_err; exp_* = outputs held afterwards
  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         kind;
    logic [7:0] exp_code;
    bit         exp_brk;
    bit         exp_ext;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int v0, e0;
    bit seen_busy;

    vecs[0]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 8'h1D, 0, 0};
    vecs[2]  = '{8'h1D, 0, 0, 1, 8'h1D, 1, 0};
    vecs[3]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0};
    vecs[4]  = '{8'hE0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[5]  = '{8'h75, 0, 0, 1, 8'h75, 0, 1};
    vecs[6]  = '{8'hE0, 0, 0, 0, 8'h75, 0, 1};
    vecs[7]  = '{8'hF0, 0, 0, 0, 8'h75, 0, 1};
    vecs[8]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1};
    vecs[9]  = '{8'hF0, 0, 0, 0, 8'h75, 1, 1};
    vecs[10] = '{8'h1D, 1, 0, 2, 8'h75, 1, 1};
    vecs[11] = '{8'h23, 0, 0, 1, 8'h23, 0, 0};
    vecs[12] = '{8'h5A, 0, 1, 2, 8'h23, 0, 0};
    vecs[13] = '{8'hE0, 0, 0, 0, 8'h23, 0, 0};
    vecs[14] = '{8'h14, 0, 0, 1, 8'h14, 0, 1};

    reset_n      = 1'b0;
    keyboardCLK  = 1'b1;
    keyboardData = 1'b1;
    wait_cyc(3);
    chk("rst_code", {24'd0, code}, 32'h00);
    chk("rst_flags", {26'd0, code_valid, is_break, is_extended, frame_err, busy, 1'b0}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(10);

    for (int i = 0; i < 15; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11);
      wait_cyc(5);
      $display("vec %0d: data=%0h kind=%0d -> code=%0h brk=%0b ext=%0b", i, vecs[i].data,
               vecs[i].kind, code, is_break, is_extended);
      chk($sformatf("v%0d_valid_cnt", i), n_valid - v0, (vecs[i].kind == 1) ? 1 : 0);
      chk($sformatf("v%0d_err_cnt", i), n_err - e0, (vecs[i].kind == 2) ? 1 : 0);
      if (vecs[i].kind == 1) chk($sformatf("v%0d_latency", i), ev_cyc, last_fall_cyc + 1 + FL + 3);
      if (vecs[i].kind == 2) chk($sformatf("v%0d_err_latency", i), err_cyc, last_fall_cyc + 1 + FL + 3);
      chk($sformatf("v%0d_code", i), {24'd0, code}, {24'd0, vecs[i].exp_code});
      chk($sformatf("v%0d_brk", i), {31'd0, is_break}, {31'd0, vecs[i].exp_brk});
      chk($sformatf("v%0d_ext", i), {31'd0, is_extended}, {31'd0, vecs[i].exp_ext});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // 2-cycle low glitch with data low: would start a frame if it got through
    v0 = n_valid;
    e0 = n_err;
    keyboardData = 1'b0;
    wait_cyc(5);
    keyboardCLK = 1'b0;
    wait_cyc(2);
    keyboardCLK = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_cyc(1);
      if (busy) seen_busy = 1'b1;
    end
    keyboardData = 1'b1;
    $display("glitch: busy_seen=%0b", seen_busy);
    chk("glitch_busy", {31'd0, seen_busy}, 32'd0);
    chk("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);

    // timeout: F0 prefix, then a 5-bit partial frame; pend must be cleared
    send_frame(8'hF0, 0, 0, 11);
    wait_cyc(10);
    e0 = n_err;
    send_frame(8'h4B, 0, 0, 5);
    chk("to_busy_mid", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 700 && n_err == e0; i++) wait_cyc(1);
    $display("timeout: err_cyc=%0d last_fall=%0d", err_cyc, last_fall_cyc);
    chk("to_err_cnt", n_err - e0, 1);
    chk("to_err_latency", err_cyc, last_fall_cyc + 1 + FL + 2 + TO);
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    v0 = n_valid;
    send_frame(8'h4B, 0, 0, 11);
    wait_cyc(5);
    $display("after timeout: code=%0h brk=%0b ext=%0b", code, is_break, is_extended);
    chk("to_next_cnt", n_valid - v0, 1);
    chk("to_next_code", {24'd0, code}, 32'h4B);
    chk("to_next_brk", {31'd0, is_break}, 32'd0);

    // asynchronous reset mid-frame
    send_frame(8'h3C, 0, 0, 7);
    chk("rst_busy_mid", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    $display("mid-frame reset: code=%0h busy=%0b", code, busy);
    chk("arst_code", {24'd0, code}, 32'h00);
    chk("arst_flags", {27'd0, code_valid, is_break, is_extended, frame_err, busy}, 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1B, 0, 0, 11);
    wait_cyc(5);
    $display("after reset: code=%0h", code);
    chk("post_rst_cnt", n_valid - v0, 1);
    chk("post_rst_err", n_err - e0, 0);
    chk("post_rst_code", {24'd0, code}, 32'h1B);
    chk("post_rst_latency", ev_cyc, last_fall_cyc + 1 + FL + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
